ram_port_arbiter: RTL and testbench

- Shares the single-port, 32-bit, byte-writable on-chip program/data RAM between three requesters: the AVR109 programming port, the CPU data bus and the CPU instruction bus.
- Per cycle it picks one request, drives the RAM port, tags the issued read, and returns read data to the owning requester one cycle later.
- Replaces ad-hoc stall logic. Adds a bounded-starvation guarantee for instruction fetch.

---
 rtl/ram_port_arbiter.sv | 151 +++++++++++++++
 tb/tb_ram_port_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Purpose : arbitrates the single-port byte-writable program/data RAM between the
//           programming port, the CPU data bus and the CPU instruction bus.
// Latency : grant and RAM drive are combinational; read data returns 1 cycle after accept.
// Backpr. : losers see ready=0 and must hold req/payload; prog port is never stalled in prog_mode.
//
// Ports
//   clk, nrst                      clock, asynchronous active-low reset
//   prog_mode                      1 = programming port owns the RAM, CPU ports blocked
//   prog_req/we/addr/wdata/wstrb   programming-port request (always accepted in prog_mode)
//   prog_rvalid/rdata              programming-port read response
//   i_req/addr, i_ready            instruction fetch request / accept
//   i_rvalid/rdata                 instruction response
//   d_req/we/addr/wdata/wstrb      data access request, d_ready accept
//   d_rvalid/rdata                 load response
//   ram_en/we/addr/wdata/rdata     RAM port (ram_rdata registered inside the RAM)

module ram_port_arbiter #(
    parameter int AW           = 14,
    parameter int STARVE_LIMIT = 4,
    parameter int SW           = 3
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          prog_mode,
    input  logic          prog_req,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [31:0]   prog_wdata,
    input  logic [3:0]    prog_wstrb,
    output logic          prog_rvalid,
    output logic [31:0]   prog_rdata,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ready,
    output logic          i_rvalid,
    output logic [31:0]   i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    input  logic [3:0]    d_wstrb,
    output logic          d_ready,
    output logic          d_rvalid,
    output logic [31:0]   d_rdata,
    output logic          ram_en,
    output logic [3:0]    ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_wdata,
    input  logic [31:0]   ram_rdata
);

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_IBUS = 2'd1,
        TAG_DBUS = 2'd2,
        TAG_PROG = 2'd3
    } tag_t;

    localparam logic [SW-1:0] LP_LIMIT = SW'(STARVE_LIMIT);

    tag_t          r_tag;
    tag_t          w_tag_nxt;
    logic [SW-1:0] r_starve_cnt;
    logic [SW-1:0] w_starve_nxt;
    logic          w_starve_hit;
    logic          w_gnt_p;
    logic          w_gnt_i;
    logic          w_gnt_d;

    // A limit of zero disables the fairness override entirely.
    assign w_starve_hit = (STARVE_LIMIT != 0) && (r_starve_cnt == LP_LIMIT);

    // Single winner per cycle; prog_mode shuts the CPU ports out completely.
    always_comb begin
        w_gnt_p = 1'b0;
        w_gnt_i = 1'b0;
        w_gnt_d = 1'b0;
        if (prog_mode) begin
            w_gnt_p = prog_req;
        end else if (i_req && (!d_req || w_starve_hit)) begin
            w_gnt_i = 1'b1;
        end else if (d_req) begin
            w_gnt_d = 1'b1;
        end
    end

    // RAM drive and response tag for the winner. A write with a zero strobe
    // still occupies the port but changes nothing and returns no data.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 4'b0000;
        ram_addr  = '0;
        ram_wdata = '0;
        w_tag_nxt = TAG_NONE;
        if (w_gnt_p) begin
            ram_en    = 1'b1;
            ram_addr  = prog_addr;
            ram_wdata = prog_wdata;
            if (prog_we) begin
                ram_we = prog_wstrb;
            end else begin
                w_tag_nxt = TAG_PROG;
            end
        end else if (w_gnt_i) begin
            ram_en    = 1'b1;
            ram_addr  = i_addr;
            w_tag_nxt = TAG_IBUS;
        end else if (w_gnt_d) begin
            ram_en    = 1'b1;
            ram_addr  = d_addr;
            ram_wdata = d_wdata;
            if (d_we) begin
                ram_we = d_wstrb;
            end else begin
                w_tag_nxt = TAG_DBUS;
            end
        end
    end

    // Counts dBus wins while a fetch is waiting; saturates at the limit so the
    // override stays armed until the fetch actually gets through.
    always_comb begin
        w_starve_nxt = r_starve_cnt;
        if (prog_mode || !i_req || w_gnt_i) begin
            w_starve_nxt = '0;
        end else if (w_gnt_d && (r_starve_cnt != LP_LIMIT)) begin
            w_starve_nxt = r_starve_cnt + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_tag        <= TAG_NONE;
            r_starve_cnt <= '0;
        end else begin
            r_tag        <= w_tag_nxt;
            r_starve_cnt <= w_starve_nxt;
        end
    end

    assign i_ready     = w_gnt_i;
    assign d_ready     = w_gnt_d;
    // rvalid decodes straight from the tag so a reset kills it immediately.
    assign i_rvalid    = (r_tag == TAG_IBUS);
    assign d_rvalid    = (r_tag == TAG_DBUS);
    assign prog_rvalid = (r_tag == TAG_PROG);
    assign i_rdata     = ram_rdata;
    assign d_rdata     = ram_rdata;
    assign prog_rdata  = ram_rdata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Purpose : self-checking bench for ram_port_arbiter with a behavioural RAM and a
//           transaction-level reference model (shadow memory + pending response).
// Latency : one model step per clock; outputs sampled on the falling edge.
// Backpr. : random requesters hold req/payload until their grant is observed.

module tb_ram_port_arbiter;

    localparam int AW    = 14;
    localparam int LIMIT = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          nrst;
    logic          prog_mode, prog_req, prog_we;
    logic [AW-1:0] prog_addr;
    logic [31:0]   prog_wdata;
    logic [3:0]    prog_wstrb;
    logic          prog_rvalid;
    logic [31:0]   prog_rdata;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_ready, i_rvalid;
    logic [31:0]   i_rdata;
    logic          d_req, d_we;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata;
    logic [3:0]    d_wstrb;
    logic          d_ready, d_rvalid;
    logic [31:0]   d_rdata;
    logic          ram_en;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    // Second instance with starvation protection disabled, sharing the inputs.
    logic          z_prog_rvalid, z_i_ready, z_i_rvalid, z_d_ready, z_d_rvalid, z_ram_en;
    logic [31:0]   z_prog_rdata, z_i_rdata, z_d_rdata, z_ram_wdata;
    logic [3:0]    z_ram_we;
    logic [AW-1:0] z_ram_addr;

    logic [31:0]   mem    [DEPTH];
    logic [31:0]   shadow [DEPTH];

    int            n_assert = 0;
    int            n_fail   = 0;
    int            m_streak;
    int            m_pend;          // 0 none, 1 ibus, 2 dbus, 3 prog
    logic [31:0]   m_pend_dat;
    logic          obs_i, obs_d, obs0_i, obs0_d;

    ram_port_arbiter #(.AW(AW), .STARVE_LIMIT(LIMIT), .SW(3)) dut (
        .clk(clk), .nrst(nrst), .prog_mode(prog_mode),
        .prog_req(prog_req), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_wdata(prog_wdata), .prog_wstrb(prog_wstrb),
        .prog_rvalid(prog_rvalid), .prog_rdata(prog_rdata),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wstrb(d_wstrb), .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    ram_port_arbiter #(.AW(AW), .STARVE_LIMIT(0), .SW(3)) dut0 (
        .clk(clk), .nrst(nrst), .prog_mode(prog_mode),
        .prog_req(prog_req), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_wdata(prog_wdata), .prog_wstrb(prog_wstrb),
        .prog_rvalid(z_prog_rvalid), .prog_rdata(z_prog_rdata),
        .i_req(i_req), .i_addr(i_addr), .i_ready(z_i_ready),
        .i_rvalid(z_i_rvalid), .i_rdata(z_i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wstrb(d_wstrb), .d_ready(z_d_ready), .d_rvalid(z_d_rvalid), .d_rdata(z_d_rdata),
        .ram_en(z_ram_en), .ram_we(z_ram_we), .ram_addr(z_ram_addr),
        .ram_wdata(z_ram_wdata), .ram_rdata(32'h0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural RAM: registered read, byte-enabled write.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we == 4'b0000) begin
                ram_rdata <= mem[ram_addr];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of checking: predict the winner from the arbitration rules,
    // compare the DUT at the falling edge, then advance the model at the rising edge.
    task automatic cycle();
        int            g;
        logic          we;
        logic [AW-1:0] a;
        logic [31:0]   wd;
        logic [3:0]    ws;
        @(negedge clk);
        g = 0;
        if (prog_mode) g = prog_req ? 3 : 0;
        else if (i_req && (!d_req || (LIMIT != 0 && m_streak >= LIMIT))) g = 1;
        else if (d_req) g = 2;
        we = 1'b0; a = '0; wd = '0; ws = '0;
        case (g)
            1: a = i_addr;
            2: begin we = d_we; a = d_addr; wd = d_wdata; ws = d_wstrb; end
            3: begin we = prog_we; a = prog_addr; wd = prog_wdata; ws = prog_wstrb; end
            default: ;
        endcase
        obs_i  = i_ready;
        obs_d  = d_ready;
        obs0_i = z_i_ready;
        obs0_d = z_d_ready;
        chk("i_ready", i_ready, g == 1);
        chk("d_ready", d_ready, g == 2);
        chk("ram_en", ram_en, g != 0);
        chk("ram_we", ram_we, (g != 0 && we) ? ws : 4'b0000);
        if (g != 0) chk("ram_addr", ram_addr, a);
        if (g != 0 && we) chk("ram_wdata", ram_wdata, wd);
        chk("i_rvalid", i_rvalid, m_pend == 1);
        chk("d_rvalid", d_rvalid, m_pend == 2);
        chk("prog_rvalid", prog_rvalid, m_pend == 3);
        case (m_pend)
            1: chk("i_rdata", i_rdata, m_pend_dat);
            2: chk("d_rdata", d_rdata, m_pend_dat);
            3: chk("prog_rdata", prog_rdata, m_pend_dat);
            default: ;
        endcase
        @(posedge clk);
        if (g != 0 && !we) begin
            m_pend     = g;
            m_pend_dat = shadow[a];
        end else begin
            m_pend = 0;
        end
        if (g != 0 && we) begin
            for (int b = 0; b < 4; b++) begin
                if (ws[b]) shadow[a][8*b +: 8] = wd[8*b +: 8];
            end
        end
        if (prog_mode || !i_req || g == 1) m_streak = 0;
        else if (g == 2 && m_streak < LIMIT) m_streak++;
        #1;
    endtask

    function automatic logic [AW-1:0] raddr();
        return AW'($urandom_range(0, 31));
    endfunction

    initial begin
        nrst = 1'b0;
        prog_mode = 0; prog_req = 0; prog_we = 0; prog_addr = '0; prog_wdata = '0; prog_wstrb = '0;
        i_req = 0; i_addr = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
        for (int k = 0; k < DEPTH; k++) begin
            mem[k]    = $urandom;
            shadow[k] = mem[k];
        end
        mem[14'h010] = 32'h0000_0013; shadow[14'h010] = 32'h0000_0013;
        mem[14'h020] = 32'h1122_3344; shadow[14'h020] = 32'h1122_3344;
        m_streak = 0; m_pend = 0; m_pend_dat = '0;

        // Reset state.
        #12;
        chk("rst_i_rvalid", i_rvalid, 1'b0);
        chk("rst_d_rvalid", d_rvalid, 1'b0);
        chk("rst_p_rvalid", prog_rvalid, 1'b0);
        chk("rst_ram_en", ram_en, 1'b0);
        chk("rst_ram_we", ram_we, 4'b0000);
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk); #1;

        // Instruction fetch of 0x010.
        i_req = 1; i_addr = 14'h010;
        cycle();
        chk("fetch_accept", obs_i, 1'b1);
        i_req = 0;
        chk("fetch_rvalid", i_rvalid, 1'b1);
        chk("fetch_rdata", i_rdata, 32'h0000_0013);
        cycle();

        // Byte write to 0x020 then read back the merged word.
        d_req = 1; d_we = 1; d_addr = 14'h020; d_wdata = 32'hAABB_CCDD; d_wstrb = 4'b0100;
        cycle();
        d_we = 0;
        cycle();
        d_req = 0;
        chk("merge_rvalid", d_rvalid, 1'b1);
        chk("merge_rdata", d_rdata, 32'h11BB_3344);
        cycle();

        // Both buses reading continuously: D,D,D,D,I repeating; limit-0 copy never fetches.
        i_req = 1; i_addr = 14'h010; d_req = 1; d_we = 0; d_addr = 14'h020;
        for (int k = 0; k < 15; k++) begin
            cycle();
            chk("starve_i", obs_i, (k % 5) == 4);
            chk("starve_d", obs_d, (k % 5) != 4);
            chk("nolimit_i", obs0_i, 1'b0);
            chk("nolimit_d", obs0_d, 1'b1);
        end
        i_req = 0;
        cycle();

        // Read in flight across a prog_mode rise; CPU requests stay blocked.
        d_req = 1; d_we = 0; d_addr = 14'h000;
        cycle();
        prog_mode = 1; i_req = 1; i_addr = 14'h004;
        prog_req = 1; prog_we = 1; prog_addr = 14'h000; prog_wdata = 32'hDEAD_BEEF; prog_wstrb = 4'hF;
        cycle();
        chk("pm_blk_i", obs_i, 1'b0);
        chk("pm_blk_d", obs_d, 1'b0);
        prog_we = 0;
        cycle();
        prog_req = 0;
        chk("prog_rvalid", prog_rvalid, 1'b1);
        chk("prog_rdata", prog_rdata, 32'hDEAD_BEEF);
        cycle();
        prog_mode = 0; i_req = 0; d_req = 0;
        cycle();

        // Reset pulse right after a fetch is accepted.
        i_req = 1; i_addr = 14'h010;
        cycle();
        chk("pre_rst_ivalid", i_rvalid, 1'b1);
        i_req = 0;
        nrst = 1'b0;
        #1;
        chk("arst_i_rvalid", i_rvalid, 1'b0);
        chk("arst_d_rvalid", d_rvalid, 1'b0);
        chk("arst_p_rvalid", prog_rvalid, 1'b0);
        m_pend = 0; m_streak = 0;
        @(negedge clk);
        nrst = 1'b1;
        for (int k = 0; k < 3; k++) cycle();

        // Random traffic; unaccepted requests are held.
        obs_i = 1; obs_d = 1;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 31) == 0) prog_mode = ~prog_mode;
            if (!i_req || obs_i) begin
                i_req  = 1'($urandom_range(0, 1));
                i_addr = raddr();
            end
            if (!d_req || obs_d) begin
                d_req   = 1'($urandom_range(0, 1));
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = raddr();
                d_wdata = $urandom;
                d_wstrb = 4'($urandom_range(0, 15));
            end
            prog_req   = 1'($urandom_range(0, 1));
            prog_we    = 1'($urandom_range(0, 1));
            prog_addr  = raddr();
            prog_wdata = $urandom;
            prog_wstrb = 4'($urandom_range(0, 15));
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
